sc_readback_checker: RTL and testbench

Downstream companion of the slow-control transmitter. It captures the serial readback stream (q_sc) that the ASIC shift register returns while a configuration frame is being shifted. It rebuilds the 829-bit frame in transmit order (LSB first) and compares it bit-for-bit against the frame that was sent. It reports pass/fail, the error count, the first mismatching bit index and a timeout; firmware uses these to confirm that the slow-control load was accepted.

---
 rtl/sc_readback_checker.sv | 141 ++++++++++++++
 tb/tb_sc_readback_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_readback_checker.sv
// Slow-control readback checker: captures the serial q_sc stream returned by the ASIC
// and compares it bit-for-bit against the frame that was transmitted.
module sc_readback_checker #(
    parameter int FRAME_LEN = 829,
    parameter int OFFSET    = 0,
    parameter int TIMEOUT   = 4096,
    parameter int CW        = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [FRAME_LEN-1:0] exp_frame,
    input  logic                 bit_valid,
    input  logic                 q_sc,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [CW-1:0]        err_count,
    output logic [CW-1:0]        first_err_idx,
    output logic                 first_err_vld,
    output logic [FRAME_LEN-1:0] rd_frame
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = (OFFSET > 1) ? $clog2(OFFSET) : 1;

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] exp_latched;
    logic [CW-1:0]        bit_cnt;
    logic [SW-1:0]        skip_cnt;
    logic [TW-1:0]        to_cnt;

    logic                 mismatch;
    logic [CW-1:0]        err_next;
    logic                 last_bit;
    logic                 skip_last;
    logic                 to_expire;

    // err_next already includes the bit being sampled so pass reflects the final count
    always_comb begin
        mismatch  = 1'b0;
        err_next  = err_count;
        last_bit  = 1'b0;
        skip_last = 1'b0;
        to_expire = 1'b0;
        mismatch  = (q_sc != exp_latched[bit_cnt]);
        err_next  = err_count + {{(CW-1){1'b0}}, mismatch};
        last_bit  = (int'(bit_cnt) == FRAME_LEN - 1);
        skip_last = (int'(skip_cnt) == OFFSET - 1);
        to_expire = (int'(to_cnt) == TIMEOUT - 1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            exp_latched   <= '0;
            bit_cnt       <= '0;
            skip_cnt      <= '0;
            to_cnt        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            rd_frame      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_latched   <= exp_frame;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        first_err_vld <= 1'b0;
                        bit_cnt       <= '0;
                        skip_cnt      <= '0;
                        to_cnt        <= '0;
                        busy          <= 1'b1;
                        state         <= (OFFSET > 0) ? SKIP : CAPTURE;
                    end
                end

                // abort beats a strobe, and a strobe beats timeout expiry
                SKIP, CAPTURE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (bit_valid) begin
                        to_cnt <= '0;
                        if (state == SKIP) begin
                            skip_cnt <= skip_cnt + 1'b1;
                            if (skip_last) begin
                                state <= CAPTURE;
                            end
                        end else begin
                            rd_frame[bit_cnt] <= q_sc;
                            err_count         <= err_next;
                            if (mismatch && !first_err_vld) begin
                                first_err_idx <= bit_cnt;
                                first_err_vld <= 1'b1;
                            end
                            bit_cnt <= bit_cnt + 1'b1;
                            if (last_bit) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (err_next == '0);
                                state <= DONE;
                            end
                        end
                    end else if (to_expire) begin
                        to_cnt  <= '0;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_readback_checker.sv
// Directed self-checking bench for sc_readback_checker (one OFFSET=0 and one OFFSET=2 instance).
module tb_sc_readback_checker;

    localparam int FL = 829;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_a;
    logic          start_b;
    logic          abort;
    logic [FL-1:0] exp_frame;
    logic          bit_valid;
    logic          q_sc;

    logic          busy_a, done_a, pass_a, timeout_a, first_err_vld_a;
    logic [CW-1:0] err_count_a, first_err_idx_a;
    logic [FL-1:0] rd_frame_a;
    logic          busy_b, done_b, pass_b, timeout_b, first_err_vld_b;
    logic [CW-1:0] err_count_b, first_err_idx_b;
    logic [FL-1:0] rd_frame_b;

    int checks = 0;
    int errors = 0;
    int done_cnt_a = 0;

    logic [FL-1:0] f1;
    logic [FL-1:0] f_err;
    int            early;
    int            dc;

    always #5 clk = ~clk;

    sc_readback_checker #(.FRAME_LEN(FL), .OFFSET(0), .TIMEOUT(64), .CW(CW)) u_dut (
        .clk(clk), .rstn(rstn), .start(start_a), .abort(abort), .exp_frame(exp_frame),
        .bit_valid(bit_valid), .q_sc(q_sc), .busy(busy_a), .done(done_a), .pass(pass_a),
        .timeout(timeout_a), .err_count(err_count_a), .first_err_idx(first_err_idx_a),
        .first_err_vld(first_err_vld_a), .rd_frame(rd_frame_a)
    );

    sc_readback_checker #(.FRAME_LEN(FL), .OFFSET(2), .TIMEOUT(64), .CW(CW)) u_off (
        .clk(clk), .rstn(rstn), .start(start_b), .abort(abort), .exp_frame(exp_frame),
        .bit_valid(bit_valid), .q_sc(q_sc), .busy(busy_b), .done(done_b), .pass(pass_b),
        .timeout(timeout_b), .err_count(err_count_b), .first_err_idx(first_err_idx_b),
        .first_err_vld(first_err_vld_b), .rd_frame(rd_frame_b)
    );

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe every two cycles over d[lo..hi]; returns on the negedge after the last sampling edge
    task automatic apply_stimulus(input logic [FL-1:0] d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            q_sc      = d[i];
            @(negedge clk);
            bit_valid = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic [FL-1:0] f, input logic use_b);
        @(negedge clk);
        exp_frame = f;
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        q_sc      = 1'b0;
        exp_frame = '0;
        for (int i = 0; i < FL; i++) f1[i] = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clk);

        check_output("rst_busy", 32'(busy_a), 32'd0);
        check_output("rst_done", 32'(done_a), 32'd0);
        check_output("rst_pass", 32'(pass_a), 32'd0);
        check_output("rst_err", 32'(err_count_a), 32'd0);
        check_output("rst_rd_zero", 32'(rd_frame_a == '0), 32'd1);
        rstn = 1'b1;

        // clean frame
        pulse_start(f1, 1'b0);
        check_output("t1_busy", 32'(busy_a), 32'd1);
        apply_stimulus(f1, 0, FL - 1);
        check_output("t1_done", 32'(done_a), 32'd1);
        check_output("t1_pass", 32'(pass_a), 32'd1);
        check_output("t1_err", 32'(err_count_a), 32'd0);
        check_output("t1_fev", 32'(first_err_vld_a), 32'd0);
        check_output("t1_rd_eq", 32'(rd_frame_a === f1), 32'd1);
        check_output("t1_busy_end", 32'(busy_a), 32'd0);
        @(negedge clk);
        check_output("t1_done_low", 32'(done_a), 32'd0);
        check_output("t1_pass_hold", 32'(pass_a), 32'd1);
        check_output("t1_done_cnt", 32'(done_cnt_a), 32'd1);

        // single-bit error at index 500
        f_err = f1;
        f_err[500] = ~f_err[500];
        pulse_start(f1, 1'b0);
        apply_stimulus(f_err, 0, FL - 1);
        check_output("t2_done", 32'(done_a), 32'd1);
        check_output("t2_pass", 32'(pass_a), 32'd0);
        check_output("t2_err", 32'(err_count_a), 32'd1);
        check_output("t2_idx", 32'(first_err_idx_a), 32'd500);
        check_output("t2_fev", 32'(first_err_vld_a), 32'd1);

        // fully inverted stream
        pulse_start(f1, 1'b0);
        apply_stimulus(~f1, 0, FL - 1);
        check_output("t3_err", 32'(err_count_a), 32'd829);
        check_output("t3_idx", 32'(first_err_idx_a), 32'd0);
        check_output("t3_pass", 32'(pass_a), 32'd0);

        // start mid-capture with a different frame is ignored
        pulse_start(f1, 1'b0);
        apply_stimulus(f1, 0, 199);
        pulse_start(~f1, 1'b0);
        apply_stimulus(f1, 200, FL - 1);
        check_output("t4_done", 32'(done_a), 32'd1);
        check_output("t4_pass", 32'(pass_a), 32'd1);
        check_output("t4_err", 32'(err_count_a), 32'd0);

        // timeout after 300 bits: done exactly 64 cycles after the last strobe edge
        pulse_start(f1, 1'b0);
        apply_stimulus(f1, 0, 299);
        early = 0;
        repeat (63) begin
            @(negedge clk);
            if (done_a !== 1'b0) early++;
        end
        check_output("t5_no_early_done", 32'(early), 32'd0);
        @(negedge clk);
        check_output("t5_done", 32'(done_a), 32'd1);
        check_output("t5_timeout", 32'(timeout_a), 32'd1);
        check_output("t5_pass", 32'(pass_a), 32'd0);
        check_output("t5_err", 32'(err_count_a), 32'd0);
        check_output("t5_rd_low", 32'(rd_frame_a[299:0] === f1[299:0]), 32'd1);

        // abort at bit 100
        pulse_start(f1, 1'b0);
        check_output("t6_timeout_clr", 32'(timeout_a), 32'd0);
        apply_stimulus(f1, 0, 99);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("t6_busy", 32'(busy_a), 32'd0);
        dc = done_cnt_a;
        repeat (100) @(negedge clk);
        check_output("t6_no_done", 32'(done_cnt_a), 32'(dc));
        check_output("t6_pass", 32'(pass_a), 32'd0);
        check_output("t6_timeout", 32'(timeout_a), 32'd0);

        // OFFSET=2 instance: two junk strobes then the real frame
        pulse_start(f1, 1'b1);
        check_output("t7_busy", 32'(busy_b), 32'd1);
        apply_stimulus(~f1, 0, 1);
        apply_stimulus(f1, 0, FL - 1);
        check_output("t7_done", 32'(done_b), 32'd1);
        check_output("t7_pass", 32'(pass_b), 32'd1);
        check_output("t7_err", 32'(err_count_b), 32'd0);
        check_output("t7_rd_eq", 32'(rd_frame_b === f1), 32'd1);

        // asynchronous reset at bit 400
        pulse_start(f1, 1'b0);
        apply_stimulus(~f1, 0, 399);
        check_output("t8_err_pre", 32'(err_count_a), 32'd400);
        #2;
        rstn = 1'b0;
        #1;
        check_output("t8_busy", 32'(busy_a), 32'd0);
        check_output("t8_err", 32'(err_count_a), 32'd0);
        check_output("t8_fev", 32'(first_err_vld_a), 32'd0);
        check_output("t8_idx", 32'(first_err_idx_a), 32'd0);
        check_output("t8_rd_zero", 32'(rd_frame_a == '0), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
